// File: rtl/data_sync_tx.sv
// data_sync_tx: source-side 4-phase launcher that holds a data bus stable for a
// multi-flop bus synchronizer in the destination domain.
module data_sync_tx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  input  logic                 ack,
  output logic                 xfer_done,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, LOAD, REQ, RELEASE} state_t;
  state_t                state_q;
  logic [NUM_STAGES-1:0] ack_sync_q, arm_q;
  logic                  ack_s, armed, accept;
  logic                  pend_vld_q, be_q, done_q;
  logic [BUS_WIDTH-1:0]  pend_data_q, bus_q;
  assign ack_s      = ack_sync_q[NUM_STAGES-1];
  assign armed      = arm_q[NUM_STAGES-1];
  assign accept     = in_valid & ~pend_vld_q;
  assign in_ready   = ~pend_vld_q;
  assign unsync_bus = bus_q;
  assign bus_enable = be_q;
  assign xfer_done  = done_q;
  assign busy       = (state_q != IDLE) | pend_vld_q;
  // arm_q fills with ones behind the ack chain so the reset-zero contents of
  // the chain are never mistaken for a real low acknowledge.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ack_sync_q <= '0;
      arm_q      <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], ack};
      arm_q      <= {arm_q[NUM_STAGES-2:0], 1'b1};
    end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q     <= IDLE;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      bus_q       <= '0;
      be_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        pend_vld_q  <= 1'b1;
        pend_data_q <= in_data;
      end
      case (state_q)
        IDLE: if (pend_vld_q & ~ack_s & armed) begin
          bus_q      <= pend_data_q;
          pend_vld_q <= 1'b0;
          state_q    <= LOAD;
        end
        LOAD: begin
          be_q    <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (ack_s) begin
          be_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= RELEASE;
        end
        RELEASE: if (~ack_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx: directed and randomized checks of data_sync_tx against a
// transaction-level destination model and word scoreboard.
module tb_data_sync_tx;
  localparam int NS = 2;
  logic       CLK = 1'b0, RST = 1'b1, in_valid = 1'b0, ack = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, bus_enable, xfer_done, busy;
  logic [7:0] unsync_bus;
  data_sync_tx #(.NUM_STAGES(NS), .BUS_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .unsync_bus(unsync_bus), .bus_enable(bus_enable), .ack(ack), .xfer_done(xfer_done), .busy(busy)
  );
  always #5 CLK = ~CLK;
  int         n_assert = 0, n_fail = 0, cyc = 0;
  int         xfer_cnt = 0, ack_rise_cyc = 0, resp_cnt = 0, resp_dly = 6, x0, a;
  logic       prev_be = 1'b0, holding = 1'b0, auto_ack = 1'b0, fall_flag = 1'b0, ok;
  logic [7:0] prev_bus = '0, held = '0;
  logic [7:0] exp_q[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_ack(input logic v);
    ack = v;
    if (v) ack_rise_cyc = cyc;
  endtask
  // One source cycle: cross the active edge, then observe at the falling edge
  // and let the destination model choose its next ack level.
  task automatic tick();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    if (bus_enable && !prev_be) begin
      chk("launch_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("bus_word", 32'(unsync_bus), 32'(exp_q.pop_front()));
      chk("bus_setup", 32'(prev_bus), 32'(unsync_bus));
      holding = 1'b1;
      held = unsync_bus;
    end
    if (holding) begin
      chk("bus_stable", 32'(unsync_bus), 32'(held));
      if (!bus_enable && !ack) holding = 1'b0;
    end
    if (prev_be && !bus_enable) chk("ack_to_fall", 32'(cyc), 32'(ack_rise_cyc + NS + 1));
    chk("done_pulse", 32'(xfer_done), 32'(prev_be && !bus_enable));
    if (xfer_done) xfer_cnt++;
    prev_be = bus_enable;
    prev_bus = unsync_bus;
    if (auto_ack) begin
      if (bus_enable && !ack) begin
        resp_cnt++;
        if (resp_cnt >= resp_dly) begin set_ack(1'b1); resp_cnt = 0; end
      end else if (!bus_enable && ack) begin
        resp_cnt++;
        if (resp_cnt >= resp_dly) begin ack = 1'b0; fall_flag = 1'b1; resp_cnt = 0; end
      end else resp_cnt = 0;
    end
  endtask
  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (in_ready === 1'b1) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end
      tick();
    end
    if (!ok) chk("push_timeout", 0, 1);
  endtask
  task automatic wait_be();
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      ok = bus_enable;
    end
    if (!ok) chk("launch_timeout", 0, 1);
  endtask
  task automatic drain();
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      tick();
      ok = exp_q.size() == 0 && busy === 1'b0 && ack === 1'b0;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_be", 32'(bus_enable), 0);
    chk("rst_bus", 32'(unsync_bus), 0);
    chk("rst_done", 32'(xfer_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    RST = 1'b0;
    repeat (4) tick();
    // single word, accept-to-request latency and busy release
    auto_ack = 1'b1;
    x0 = xfer_cnt;
    fall_flag = 1'b0;
    push(8'hA5);
    in_valid = 1'b0;
    chk("t1_ready_low", 32'(in_ready), 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_be_e0", 32'(bus_enable), 0);
    tick();
    chk("t1_bus", 32'(unsync_bus), 32'h A5);
    chk("t1_ready_back", 32'(in_ready), 1);
    chk("t1_be_e1", 32'(bus_enable), 0);
    tick();
    chk("t1_be_e2", 32'(bus_enable), 1);
    for (int k = 0; k < 100 && !fall_flag; k++) tick();
    chk("t1_ack_fell", 32'(fall_flag), 1);
    tick();
    tick();
    chk("t1_busy_sync", 32'(busy), 1);
    tick();
    chk("t1_busy_clear", 32'(busy), 0);
    chk("t1_pulses", 32'(xfer_cnt - x0), 1);
    // back-to-back words with valid held high
    x0 = xfer_cnt;
    push(8'h11);
    push(8'h22);
    chk("b2b_ready_drop", 32'(in_ready), 0);
    push(8'h33);
    in_valid = 1'b0;
    drain();
    chk("b2b_pulses", 32'(xfer_cnt - x0), 3);
    // sub-cycle ack glitch during REQ
    auto_ack = 1'b0;
    x0 = xfer_cnt;
    push(8'h3C);
    in_valid = 1'b0;
    wait_be();
    #2 ack = 1'b1;
    #2 ack = 1'b0;
    repeat (6) tick();
    chk("glitch_be", 32'(bus_enable), 1);
    chk("glitch_no_done", 32'(xfer_cnt - x0), 0);
    set_ack(1'b1);
    auto_ack = 1'b1;
    drain();
    chk("glitch_done", 32'(xfer_cnt - x0), 1);
    // reset during REQ with a second word pending
    auto_ack = 1'b0;
    push(8'hC3);
    in_valid = 1'b0;
    wait_be();
    push(8'h7E);
    in_valid = 1'b0;
    chk("mid_pending", 32'(in_ready), 0);
    RST = 1'b1;
    #1;
    chk("mid_be", 32'(bus_enable), 0);
    chk("mid_bus", 32'(unsync_bus), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(xfer_done), 0);
    chk("mid_ready", 32'(in_ready), 1);
    exp_q.delete();
    prev_be = 1'b0;
    holding = 1'b0;
    prev_bus = '0;
    tick();
    tick();
    RST = 1'b0;
    repeat (20) tick();
    chk("mid_no_stale_be", 32'(bus_enable), 0);
    chk("mid_no_stale_busy", 32'(busy), 0);
    chk("mid_ready_after", 32'(in_ready), 1);
    // ack held high through reset release
    set_ack(1'b1);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    push(8'h5A);
    in_valid = 1'b0;
    repeat (8) tick();
    chk("stuck_be", 32'(bus_enable), 0);
    chk("stuck_busy", 32'(busy), 1);
    ack = 1'b0;
    a = cyc;
    repeat (3) tick();
    chk("stuck_wait", 32'(bus_enable), 0);
    tick();
    chk("stuck_launch", 32'(bus_enable), 1);
    chk("stuck_timing", 32'(cyc - a), 32'(NS + 2));
    auto_ack = 1'b1;
    drain();
    // randomized words, gaps and destination latency
    x0 = xfer_cnt;
    for (int i = 0; i < 10; i++) begin
      resp_dly = $urandom_range(1, 8);
      push(8'($urandom));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    chk("rand_pulses", 32'(xfer_cnt - x0), 10);
    chk("rand_idle", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/data_sync_tx.md
# data_sync_tx

Source-side launcher for the multi-flop bus synchronizer in the destination domain. It accepts words from a local valid/ready producer and drives a held data bus plus a level enable toward the destination domain. It runs a 4-phase request/acknowledge handshake against an asynchronous `ack` returned from that domain. It guarantees that `unsync_bus` is stable from before `bus_enable` rises until the destination has acknowledged and released, so the receiver's rising-edge capture is always safe.

## Interface
- `NUM_STAGES`, 2, depth of the `ack` synchronizer chain; legal values are 2 and above.
- `BUS_WIDTH`, 8, width of the data path.

- `CLK`  in  1  source-domain clock
- `RST`  in  1  asynchronous, active-high reset
- `in_data`  in  BUS_WIDTH  word from the local producer
- `in_valid`  in  1  `in_data` is valid this cycle
- `in_ready`  out  1  block can accept a word this cycle (combinational, equal to `~pend_vld`)
- `unsync_bus`  out  BUS_WIDTH  held data toward the destination synchronizer (registered)
- `bus_enable`  out  1  4-phase request level toward the destination (registered)
- `ack`  in  1  asynchronous acknowledge level from the destination domain
- `xfer_done`  out  1  one-cycle pulse when a transfer is acknowledged (registered)
- `busy`  out  1  a word is pending or in flight

## Operation
- **Acknowledge synchronizer:** `ack` passes through a `NUM_STAGES`-flop shift chain. Its last stage, `ack_s`, is the only form of `ack` used internally.
- **Pending register:** `pend_vld` and `pend_data` hold one word.
  - A word is accepted on an edge where `in_valid & in_ready`; that edge sets `pend_vld` and loads `pend_data`.
  - Data offered while `in_ready` is 0 is ignored. The producer must hold it.
- **FSM states:** IDLE, LOAD, REQ, RELEASE.
  - IDLE: if `pend_vld & ~ack_s`, load `unsync_bus <= pend_data`, clear `pend_vld` and go to LOAD. Otherwise stay in IDLE.
  - LOAD: set `bus_enable <= 1` and go to REQ. This gives one full cycle of data setup before the request rises.
  - REQ: hold `bus_enable` high. When `ack_s == 1`, set `bus_enable <= 0`, pulse `xfer_done <= 1` and go to RELEASE.
  - RELEASE: wait for `ack_s == 0`, then go to IDLE.
- **Data stability:** `unsync_bus` changes only on the IDLE→LOAD edge, never in LOAD, REQ or RELEASE.
- **busy:** `busy = (state != IDLE) | pend_vld`.
- **Back-to-back transfers:** a new word may be accepted while a transfer is in flight. It launches from IDLE after RELEASE completes.
- **Reset:**
  - Asynchronous and active-high.
  - Clears the state to IDLE and sets `bus_enable`, `xfer_done`, `unsync_bus`, `pend_vld`, `pend_data` and all synchronizer flops to 0.
  - A reset in the middle of a transfer drops the in-flight and pending words. The destination sees `bus_enable` fall, which is a legal 4-phase release.
- **`ack` already high:** if `ack` is high at reset release or in IDLE, the block does not launch until `ack_s` has been low for at least one cycle while in IDLE.
- **`ack` deasserting during REQ:** a glitch or early deassert of `ack` has no effect. Only `ack_s == 1` advances the FSM.

## Timing
- **Accept to request:** accept at edge 0 from an empty, idle block with `ack_s == 0`:
  - `pend_vld` goes to 1 after edge 0.
  - `unsync_bus` is loaded and `in_ready` returns to 1 after edge 1.
  - `bus_enable` goes to 1 after edge 2.
- **Acknowledge latency:** `ack_s` rises `NUM_STAGES` edges after `ack` is sampled high. `bus_enable` falls and `xfer_done` pulses on the next edge after that.
- **Minimum cycle:** one transfer takes 4 source cycles plus the destination round trip plus 2×`NUM_STAGES` for the acknowledge rise and fall.
- **Pulse width:** `xfer_done` is exactly 1 cycle wide per transfer.
- **Outputs:** `unsync_bus`, `bus_enable` and `xfer_done` are registered, so their outputs are glitch-free.

## Test plan
- **Single word:** `NUM_STAGES=2`; drive `in_data=0xA5` with `in_valid` for 1 cycle; the bench model raises `ack` 6 cycles after `bus_enable` and lowers it 6 cycles after `bus_enable` falls.
  - `unsync_bus=0xA5` one cycle before `bus_enable=1`.
  - `bus_enable` falls 3 edges after `ack` rises, i.e. after the 2-stage sync.
  - `xfer_done` pulses once.
  - `busy` returns to 0 after `ack_s` falls.
- **Back-to-back:** push 0x11, 0x22 and 0x33 with `in_valid` held high.
  - `in_ready` drops while pending is full.
  - `unsync_bus` presents 0x11, 0x22 and 0x33 in order, each constant throughout its REQ and RELEASE.
  - Exactly 3 `xfer_done` pulses.
- **Stuck acknowledge:** hold `ack` high through reset release and push 0x5A.
  - `bus_enable` stays 0 until `ack` has been low for ≥ `NUM_STAGES+1` cycles, then launches normally.
- **Mid-transfer reset:** assert `RST` during REQ with a second word pending.
  - `bus_enable`, `unsync_bus`, `busy` and `xfer_done` go to 0 immediately (asynchronously).
  - After release, `in_ready=1` and no stale word is launched.
- **Acknowledge glitch:** pulse `ack` high for less than 1 cycle, not captured by `ack_s`, during REQ.
  - `bus_enable` remains 1 and no `xfer_done` is produced.
  - A proper `ack` later completes the transfer.
